// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter for the single-port data memory (dmem syncram).
//   Requester A (processor load/store port) has priority in IDLE. Requester B
//   (debug/loader port) can hold the bus with b_lock for bursts. Each cycle,
//   at most one access is issued. The requester that issued a read gets the
//   read data back one cycle later.
//
//   Optional feature macro: DMEM_ARB_STARVE_GUARD_EN
//     defined   -> wait_cnt starvation guard. B wins after MAX_WAIT
//                  consecutive losing cycles.
//     undefined -> strict A priority in IDLE.
//
// Ports
//   clock, reset             : clock, async active-high reset
//   a_req/a_wren/a_addr/a_data : requester A access
//   a_gnt, a_rvalid, a_q     : A grant, A read return
//   b_req/b_wren/b_lock/b_addr/b_data : requester B access and bus hold
//   b_gnt, b_rvalid, b_q     : B grant, B read return
//   mem_addr/mem_data/mem_wren : drive the dmem ports
//   mem_q                    : dmem read data
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | normal arbitration, A priority (subject to starvation guard)
// LOCK_B| B holds the bus; A blocked until b_lock drops
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_q,
    input  logic              b_req,
    input  logic              b_wren,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCK_B = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] rd_owner;
    logic       force_b;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    assign force_b = b_req && (wait_cnt == WAIT_MAX);

    // Counts consecutive cycles where B asks but loses; saturates at MAX_WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!b_req || b_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign force_b = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (force_b) begin
                    b_gnt = 1'b1;
                end else if (a_req) begin
                    a_gnt = 1'b1;
                end else if (b_req) begin
                    b_gnt = 1'b1;
                end
                if (b_gnt && b_lock) begin
                    state_nxt = LOCK_B;
                end
            end
            LOCK_B: begin
                b_gnt = b_req;
                if (!b_lock) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Grants drop asynchronously while reset is held. This also forces
        // the mem_* outputs to zero.
        if (reset) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        if (a_gnt) begin
            mem_addr = a_addr;
            mem_data = a_data;
            mem_wren = a_wren;
        end else if (b_gnt) begin
            mem_addr = b_addr;
            mem_data = b_data;
            mem_wren = b_wren;
        end
    end

    // The syncram registers its address, so read data returns one cycle
    // after the grant. Remember who issued the read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_owner <= 2'b00;
        end else begin
            rd_owner <= {b_gnt & ~b_wren, a_gnt & ~a_wren};
        end
    end

    assign a_rvalid = rd_owner[0];
    assign b_rvalid = rd_owner[1];
    assign a_q      = mem_q;
    assign b_q      = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_req, a_wren, a_gnt, a_rvalid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data, a_q;
    logic              b_req, b_wren, b_lock, b_gnt, b_rvalid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data, b_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data, mem_q;
    logic              mem_wren;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_wren(a_wren), .a_addr(a_addr), .a_data(a_data),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_q(a_q),
        .b_req(b_req), .b_wren(b_wren), .b_lock(b_lock), .b_addr(b_addr),
        .b_data(b_data), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_q(b_q),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    // Registered-address syncram. Location i is preloaded with 0xCAFE0000 | i.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr_q = '0;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hCAFE0000 | i;
    end

    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        addr_q <= mem_addr;
    end

    assign mem_q = mem[addr_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and are checked 2 units later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 0; a_wren = 0; a_addr = '0; a_data = '0;
        b_req = 0; b_wren = 0; b_lock = 0; b_addr = '0; b_data = '0;
        step();
        step();
        #2;
        chk("rst_hold_a_rvalid", a_rvalid, 0);
        chk("rst_hold_mem_wren", mem_wren, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_mem_addr", mem_addr, 0);
        chk("post_rst_gnts", {a_gnt, b_gnt}, 0);

        // 1. Reset raised mid-cycle during contention
        step();
        a_req = 1; a_addr = 12'h010;
        #2;
        chk("t1_a_gnt_rd", a_gnt, 1);
        step();
        a_wren = 1; a_addr = 12'h040; a_data = 32'h0BAD0BAD;
        b_req = 1; b_addr = 12'h050;
        #2;
        chk("t1_a_rvalid_pre", a_rvalid, 1);
        chk("t1_mem_wren_pre", mem_wren, 1);
        reset = 1'b1;
        #1;
        chk("t1_rst_gnts", {a_gnt, b_gnt}, 0);
        chk("t1_rst_mem_wren", mem_wren, 0);
        chk("t1_rst_rvalids", {a_rvalid, b_rvalid}, 0);
        step();
        a_req = 0; a_wren = 0; b_req = 0;
        reset = 1'b0;
        #2;
        chk("t1_idle_mem_addr", mem_addr, 0);

        // 2. Contention: A wins, then B
        step();
        a_req = 1; a_addr = 12'h010;
        b_req = 1; b_addr = 12'h020;
        #2;
        chk("t2_a_gnt", a_gnt, 1);
        chk("t2_b_gnt0", b_gnt, 0);
        chk("t2_mem_addr_a", mem_addr, 12'h010);
        step();
        a_req = 0;
        #2;
        chk("t2_a_rvalid", a_rvalid, 1);
        chk("t2_a_q", a_q, 32'hCAFE0010);
        chk("t2_b_gnt1", b_gnt, 1);
        chk("t2_mem_addr_b", mem_addr, 12'h020);
        step();
        b_req = 0;
        #2;
        chk("t2_b_rvalid", b_rvalid, 1);
        chk("t2_b_q", b_q, 32'hCAFE0020);
        chk("t2_a_rvalid0", a_rvalid, 0);

        // 3. Starvation under continuous A reads
        step();
        a_req = 1; a_addr = 12'h030;
        b_req = 1; b_wren = 1; b_addr = 12'h005; b_data = 32'hDEADBEEF;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t3_b_loses", {a_gnt, b_gnt}, 2'b10);
            step();
        end
        #2;
        chk("t3_b_forced", {a_gnt, b_gnt}, 2'b01);
        chk("t3_mem_wren", mem_wren, 1);
        chk("t3_mem_addr", mem_addr, 12'h005);
        chk("t3_mem_data", mem_data, 32'hDEADBEEF);
        step();
        b_req = 0; b_wren = 0;
        #2;
        chk("t3_a_again", a_gnt, 1);
`else
        for (int i = 0; i < 20; i++) begin
            #2;
            chk("t3_b_starved", {a_gnt, b_gnt}, 2'b10);
            step();
        end
        a_req = 0;
        #2;
        chk("t3_b_after_a", b_gnt, 1);
        chk("t3_mem_wren", mem_wren, 1);
        step();
        b_req = 0; b_wren = 0;
`endif
        step();
        a_req = 0;
        b_req = 1; b_addr = 12'h005;
        #2;
        chk("t3_b_rd_gnt", b_gnt, 1);
        step();
        b_req = 0;
        #2;
        chk("t3_written_data", b_q, 32'hDEADBEEF);

        // 4. Lock
        step();
        b_req = 1; b_lock = 1; b_addr = 12'h100;
        #2;
        chk("t4_b_gnt", b_gnt, 1);
        step();
        b_req = 0; a_req = 1; a_addr = 12'h011;
        #2;
        chk("t4_b_rvalid", b_rvalid, 1);
        chk("t4_b_q", b_q, 32'hCAFE0100);
        for (int i = 0; i < 3; i++) begin
            chk("t4_a_blocked", {a_gnt, b_gnt}, 2'b00);
            step();
            #2;
        end
        b_lock = 0;
        #1;
        chk("t4_exit_cycle", a_gnt, 0);
        step();
        #2;
        chk("t4_a_after_unlock", a_gnt, 1);
        chk("t4_mem_addr", mem_addr, 12'h011);

        // 5. Reset while in LOCK_B
        step();
        a_req = 0;
        b_req = 1; b_lock = 1; b_addr = 12'h101;
        step();
        a_req = 1; a_addr = 12'h012;
        #2;
        chk("t5_locked", {a_gnt, b_gnt}, 2'b01);
        reset = 1'b1;
        #1;
        chk("t5_rst_b_gnt", b_gnt, 0);
        step();
        reset = 1'b0;
        #2;
        chk("t5_a_wins", {a_gnt, b_gnt}, 2'b10);
        step();
        a_req = 0; b_req = 0; b_lock = 0;

        // 6. A writes, B reads back
        step();
        a_req = 1; a_wren = 1; a_addr = 12'h0AA; a_data = 32'h12345678;
        #2;
        chk("t6_a_wr_gnt", {a_gnt, mem_wren}, 2'b11);
        step();
        a_req = 0; a_wren = 0;
        b_req = 1; b_addr = 12'h0AA;
        #2;
        chk("t6_a_rvalid0_1", a_rvalid, 0);
        chk("t6_b_gnt", b_gnt, 1);
        step();
        b_req = 0;
        #2;
        chk("t6_b_rvalid", b_rvalid, 1);
        chk("t6_b_q", b_q, 32'h12345678);
        chk("t6_a_rvalid0_2", a_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
